trdb_trace_ctrl: RTL and testbench

TRDB_TRACE_CTRL -- requirements
Module: trdb_trace_ctrl

---
 rtl/trdb_trace_ctrl.sv | 129 ++++++++++++
 tb/tb_trdb_trace_ctrl.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/trdb_trace_ctrl.sv
// Trace start/stop controller: arms on a qualified, enabled instruction stream, flags the first
// and last traced retirements, then drains the packet emitter with a bounded flush.
module trdb_trace_ctrl #(
   parameter int unsigned FLUSH_TIMEOUT = 16
) (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic       trace_activated_i,
   input  logic [3:0] trigger_i,
   input  logic       qualified_i,
   input  logic       iretire_i,
   input  logic       flush_done_i,
   output logic       trace_active_o,
   output logic       first_qualified_o,
   output logic       last_qualified_o,
   output logic       flush_req_o,
   output logic       trace_req_deactivate_o,
   output logic       flush_timeout_o
);

   typedef enum logic [1:0] {
      StIdle,
      StWaitFirst,
      StTracing,
      StFlush
   } state_e;

   localparam logic [3:0] TrigOff     = 4'd3;
   localparam logic [7:0] TimeoutLast = 8'(FLUSH_TIMEOUT - 1);

   state_e     state_q, state_d;
   logic [7:0] cnt_q, cnt_d;
   logic       stop_by_trig_q, stop_by_trig_d;

   logic trig_off;
   logic start_cond;
   logic stop_cond;

   // Trace-on (code 2) needs no decode: starting is governed purely by start_cond.
   assign trig_off   = (trigger_i == TrigOff);
   assign start_cond = trace_activated_i & qualified_i & ~trig_off;
   assign stop_cond  = ~trace_activated_i | ~qualified_i | trig_off;

   always_comb begin
      state_d                = state_q;
      cnt_d                  = cnt_q;
      stop_by_trig_d         = stop_by_trig_q;
      trace_active_o         = 1'b0;
      first_qualified_o      = 1'b0;
      last_qualified_o       = 1'b0;
      flush_req_o            = 1'b0;
      trace_req_deactivate_o = 1'b0;
      flush_timeout_o        = 1'b0;

      unique case (state_q)
         StIdle: begin
            cnt_d          = '0;
            stop_by_trig_d = 1'b0;
            if (start_cond) begin
               state_d = StWaitFirst;
            end
         end

         StWaitFirst: begin
            // A stop in the same cycle as the retirement cancels the start silently.
            if (stop_cond) begin
               state_d = StIdle;
            end else if (iretire_i) begin
               first_qualified_o = 1'b1;
               state_d           = StTracing;
            end
         end

         StTracing: begin
            trace_active_o = 1'b1;
            if (stop_cond) begin
               last_qualified_o = 1'b1;
               state_d          = StFlush;
               cnt_d            = '0;
               stop_by_trig_d   = trig_off;
            end
         end

         StFlush: begin
            flush_req_o = 1'b1;
            cnt_d       = cnt_q + 8'd1;
            // A drain that completes on the timeout cycle still counts as a normal completion.
            if (flush_done_i) begin
               trace_req_deactivate_o = stop_by_trig_q;
               state_d                = StIdle;
               cnt_d                  = '0;
               stop_by_trig_d         = 1'b0;
            end else if (cnt_q == TimeoutLast) begin
               flush_timeout_o        = 1'b1;
               trace_req_deactivate_o = stop_by_trig_q;
               state_d                = StIdle;
               cnt_d                  = '0;
               stop_by_trig_d         = 1'b0;
            end
         end

         default: begin
            state_d = StIdle;
         end
      endcase

      if (rst_i) begin
         trace_active_o         = 1'b0;
         first_qualified_o      = 1'b0;
         last_qualified_o       = 1'b0;
         flush_req_o            = 1'b0;
         trace_req_deactivate_o = 1'b0;
         flush_timeout_o        = 1'b0;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q        <= StIdle;
         cnt_q          <= '0;
         stop_by_trig_q <= 1'b0;
      end else begin
         state_q        <= state_d;
         cnt_q          <= cnt_d;
         stop_by_trig_q <= stop_by_trig_d;
      end
   end

endmodule

// File: tb/tb_trdb_trace_ctrl.sv
// Scoreboard bench for trdb_trace_ctrl: each scenario queues expected output vectors as it drives
// stimulus and compares them mid-cycle against the DUT outputs.
module tb_trdb_trace_ctrl;

   logic       clk = 1'b0;
   logic       rst;
   logic       act;
   logic [3:0] trig;
   logic       qual;
   logic       iret;
   logic       done;
   logic       active, first, last, freq, deact, tmo;

   always #5 clk = ~clk;

   trdb_trace_ctrl #(.FLUSH_TIMEOUT(16)) dut (
      .clk_i                 (clk),
      .rst_i                 (rst),
      .trace_activated_i     (act),
      .trigger_i             (trig),
      .qualified_i           (qual),
      .iretire_i             (iret),
      .flush_done_i          (done),
      .trace_active_o        (active),
      .first_qualified_o     (first),
      .last_qualified_o      (last),
      .flush_req_o           (freq),
      .trace_req_deactivate_o(deact),
      .flush_timeout_o       (tmo)
   );

   // Output vector order: {active, first, last, flush_req, deactivate, timeout}
   localparam logic [5:0] ONone      = 6'b000000;
   localparam logic [5:0] OFirst     = 6'b010000;
   localparam logic [5:0] OTrace     = 6'b100000;
   localparam logic [5:0] OLast      = 6'b101000;
   localparam logic [5:0] OFlush     = 6'b000100;
   localparam logic [5:0] ODoneDeact = 6'b000110;
   localparam logic [5:0] OTmo       = 6'b000101;

   typedef struct packed {
      logic       rst;
      logic       act;
      logic [3:0] trig;
      logic       qual;
      logic       iret;
      logic       done;
      logic [5:0] exp;
   } stim_t;

   logic [5:0] exp_q[$];
   int n_checks = 0;
   int n_fail   = 0;

   function automatic stim_t mk(input logic r, input logic a, input logic [3:0] t, input logic q,
                                input logic i, input logic d, input logic [5:0] e);
      stim_t s;
      s.rst  = r;
      s.act  = a;
      s.trig = t;
      s.qual = q;
      s.iret = i;
      s.done = d;
      s.exp  = e;
      return s;
   endfunction

   // Drive one cycle of stimulus just after the rising edge and queue its expected outputs.
   task automatic apply(input stim_t s);
      @(posedge clk);
      #1;
      rst  = s.rst;
      act  = s.act;
      trig = s.trig;
      qual = s.qual;
      iret = s.iret;
      done = s.done;
      exp_q.push_back(s.exp);
   endtask

   task automatic test_reset();
      stim_t s[$];
      logic [5:0] e;
      s.push_back(mk(1, 1, 4'd0, 1, 1, 1, ONone));
      s.push_back(mk(1, 1, 4'd3, 0, 1, 1, ONone));
      s.push_back(mk(1, 0, 4'd0, 0, 0, 0, ONone));
      s.push_back(mk(0, 0, 4'd2, 0, 1, 1, ONone));
      foreach (s[i]) begin
         apply(s[i]);
         @(negedge clk);
         e = exp_q.pop_front();
         n_checks++;
         if ({active, first, last, freq, deact, tmo} !== e) begin
            n_fail++;
            $display("FAIL reset[%0d]: outputs=%b expected=%b", i,
                     {active, first, last, freq, deact, tmo}, e);
         end
      end
   endtask

   task automatic test_basic_start();
      stim_t s[$];
      logic [5:0] e;
      s.push_back(mk(1, 0, 4'd0, 0, 0, 0, ONone));
      s.push_back(mk(0, 1, 4'd0, 1, 1, 0, ONone));
      s.push_back(mk(0, 1, 4'd0, 1, 1, 0, OFirst));
      s.push_back(mk(0, 1, 4'd0, 1, 1, 0, OTrace));
      s.push_back(mk(0, 1, 4'd2, 1, 1, 0, OTrace));
      s.push_back(mk(0, 1, 4'd0, 1, 0, 0, OTrace));
      foreach (s[i]) begin
         apply(s[i]);
         @(negedge clk);
         e = exp_q.pop_front();
         n_checks++;
         if ({active, first, last, freq, deact, tmo} !== e) begin
            n_fail++;
            $display("FAIL basic_start[%0d]: outputs=%b expected=%b", i,
                     {active, first, last, freq, deact, tmo}, e);
         end
      end
   endtask

   // Starts in TRACING (left there by test_basic_start).
   task automatic test_trigger_stop();
      stim_t s[$];
      logic [5:0] e;
      s.push_back(mk(0, 1, 4'd3, 1, 1, 0, OLast));
      s.push_back(mk(0, 1, 4'd0, 1, 1, 0, OFlush));
      s.push_back(mk(0, 1, 4'd0, 1, 1, 0, OFlush));
      s.push_back(mk(0, 1, 4'd0, 1, 1, 1, ODoneDeact));
      s.push_back(mk(0, 0, 4'd0, 0, 0, 0, ONone));
      foreach (s[i]) begin
         apply(s[i]);
         @(negedge clk);
         e = exp_q.pop_front();
         n_checks++;
         if ({active, first, last, freq, deact, tmo} !== e) begin
            n_fail++;
            $display("FAIL trigger_stop[%0d]: outputs=%b expected=%b", i,
                     {active, first, last, freq, deact, tmo}, e);
         end
      end
   endtask

   // Trigger-off beats retire in WAIT_FIRST; then done coinciding with the timeout cycle.
   task automatic test_simultaneous();
      stim_t s[$];
      logic [5:0] e;
      s.push_back(mk(0, 1, 4'd0, 1, 0, 0, ONone));
      s.push_back(mk(0, 1, 4'd3, 1, 1, 0, ONone));
      s.push_back(mk(0, 1, 4'd0, 1, 1, 0, ONone));
      s.push_back(mk(0, 1, 4'd0, 1, 1, 0, OFirst));
      s.push_back(mk(0, 1, 4'd3, 1, 1, 0, OLast));
      for (int k = 0; k < 15; k++) s.push_back(mk(0, 1, 4'd0, 1, 1, 0, OFlush));
      s.push_back(mk(0, 1, 4'd0, 1, 1, 1, ODoneDeact));
      s.push_back(mk(0, 0, 4'd0, 0, 0, 0, ONone));
      foreach (s[i]) begin
         apply(s[i]);
         @(negedge clk);
         e = exp_q.pop_front();
         n_checks++;
         if ({active, first, last, freq, deact, tmo} !== e) begin
            n_fail++;
            $display("FAIL simultaneous[%0d]: outputs=%b expected=%b", i,
                     {active, first, last, freq, deact, tmo}, e);
         end
      end
   endtask

   task automatic test_timeout();
      stim_t s[$];
      logic [5:0] e;
      s.push_back(mk(0, 1, 4'd0, 1, 0, 0, ONone));
      s.push_back(mk(0, 1, 4'd0, 1, 0, 0, ONone));
      s.push_back(mk(0, 1, 4'd0, 1, 1, 0, OFirst));
      s.push_back(mk(0, 1, 4'd0, 0, 1, 0, OLast));
      for (int k = 0; k < 15; k++) s.push_back(mk(0, 1, 4'd0, 0, 1, 0, OFlush));
      s.push_back(mk(0, 1, 4'd0, 0, 1, 0, OTmo));
      s.push_back(mk(0, 1, 4'd0, 0, 1, 0, ONone));
      foreach (s[i]) begin
         apply(s[i]);
         @(negedge clk);
         e = exp_q.pop_front();
         n_checks++;
         if ({active, first, last, freq, deact, tmo} !== e) begin
            n_fail++;
            $display("FAIL timeout[%0d]: outputs=%b expected=%b", i,
                     {active, first, last, freq, deact, tmo}, e);
         end
      end
   endtask

   // Reset on the fifth FLUSH cycle, restart, then a full timeout proves the counter was cleared.
   task automatic test_reset_mid_flush();
      stim_t s[$];
      logic [5:0] e;
      s.push_back(mk(0, 1, 4'd0, 1, 1, 0, ONone));
      s.push_back(mk(0, 1, 4'd0, 1, 1, 0, OFirst));
      s.push_back(mk(0, 1, 4'd3, 1, 1, 0, OLast));
      for (int k = 0; k < 4; k++) s.push_back(mk(0, 1, 4'd0, 1, 1, 0, OFlush));
      s.push_back(mk(1, 1, 4'd0, 1, 1, 1, ONone));
      s.push_back(mk(0, 1, 4'd0, 1, 1, 1, ONone));
      s.push_back(mk(0, 1, 4'd0, 1, 1, 0, OFirst));
      s.push_back(mk(0, 1, 4'd0, 1, 1, 0, OTrace));
      s.push_back(mk(0, 1, 4'd0, 0, 1, 0, OLast));
      for (int k = 0; k < 15; k++) s.push_back(mk(0, 1, 4'd0, 0, 1, 0, OFlush));
      s.push_back(mk(0, 1, 4'd0, 0, 1, 0, OTmo));
      s.push_back(mk(0, 0, 4'd0, 0, 0, 0, ONone));
      foreach (s[i]) begin
         apply(s[i]);
         @(negedge clk);
         e = exp_q.pop_front();
         n_checks++;
         if ({active, first, last, freq, deact, tmo} !== e) begin
            n_fail++;
            $display("FAIL reset_mid_flush[%0d]: outputs=%b expected=%b", i,
                     {active, first, last, freq, deact, tmo}, e);
         end
      end
   endtask

   initial begin
      rst  = 1'b1;
      act  = 1'b0;
      trig = 4'd0;
      qual = 1'b0;
      iret = 1'b0;
      done = 1'b0;
      test_reset();
      test_basic_start();
      test_trigger_stop();
      test_simultaneous();
      test_timeout();
      test_reset_mid_flush();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
